// File: rtl/temporizador_pkg.sv
// Shared types and default constants for the multichannel countdown timer.
package temporizador_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } estado_t;

    localparam int unsigned CLK_HZ_DEF = 25_000_000;
    localparam int unsigned SEC_W_DEF  = 7;

endpackage

// File: rtl/temporizador_canal.sv
// One countdown channel: prescaler, state machine and count register.
// Optional warn output when TEMP_WARN_EN is defined.
import temporizador_pkg::*;

module temporizador_canal #(
    parameter int unsigned DIV   = 10,
    parameter int unsigned SEC_W = SEC_W_DEF
`ifdef TEMP_WARN_EN
    , parameter int unsigned WARN_SEC = 3
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic [SEC_W-1:0] load_val,
    output logic [SEC_W-1:0] remaining,
    output logic             running,
    output logic             expired,
    output logic             expire_pulse
`ifdef TEMP_WARN_EN
    , output logic           warn
`endif
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    estado_t          estado;
    logic [PW-1:0]    presc;
    logic [SEC_W-1:0] cuenta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado       <= IDLE;
            presc        <= '0;
            cuenta       <= '0;
            expire_pulse <= 1'b0;
        end else begin
            expire_pulse <= 1'b0;
            if (start) begin
                cuenta <= load_val;
                presc  <= '0;
                if (load_val == '0) begin
                    estado       <= DONE;
                    expire_pulse <= 1'b1;
                end else begin
                    estado <= RUN;
                end
            end else if (stop) begin
                estado <= IDLE;
                cuenta <= '0;
                presc  <= '0;
            end else if (estado == RUN || estado == PAUSED) begin
                // Resuming edge counts as a RUN edge so a pause of N cycles delays exactly N.
                if (pause) begin
                    estado <= PAUSED;
                end else begin
                    estado <= RUN;
                    if (presc == PRE_MAX) begin
                        presc  <= '0;
                        cuenta <= cuenta - SEC_W'(1);
                        if (cuenta == SEC_W'(1)) begin
                            estado       <= DONE;
                            expire_pulse <= 1'b1;
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
            end
        end
    end

    assign remaining = cuenta;
    assign running   = (estado == RUN) || (estado == PAUSED);
    assign expired   = (estado == DONE);

`ifdef TEMP_WARN_EN
    assign warn = running && (cuenta != '0) && (cuenta <= SEC_W'(WARN_SEC));
`endif

endmodule

// File: rtl/temporizador_multicanal.sv
// N_CH independent countdown timers sharing one clock and reset.
// Define TEMP_WARN_EN to add the per-channel warn output.
import temporizador_pkg::*;

module temporizador_multicanal #(
    parameter int unsigned CLK_HZ   = CLK_HZ_DEF,
    parameter int unsigned TICK_HZ  = 1,
    parameter int unsigned N_CH     = 2,
    parameter int unsigned SEC_W    = SEC_W_DEF,
    parameter int unsigned WARN_SEC = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       start,
    input  logic [N_CH-1:0]       pause,
    input  logic [N_CH-1:0]       stop,
    input  logic [N_CH*SEC_W-1:0] load_val,
    output logic [N_CH*SEC_W-1:0] remaining,
    output logic [N_CH-1:0]       running,
    output logic [N_CH-1:0]       expired,
    output logic [N_CH-1:0]       expire_pulse
`ifdef TEMP_WARN_EN
    , output logic [N_CH-1:0]     warn
`endif
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;

    for (genvar i = 0; i < N_CH; i++) begin : g_canal
`ifdef TEMP_WARN_EN
        temporizador_canal #(
            .DIV      (DIV),
            .SEC_W    (SEC_W),
            .WARN_SEC (WARN_SEC)
        ) u_canal (
            .clk          (clk),
            .reset        (reset),
            .start        (start[i]),
            .pause        (pause[i]),
            .stop         (stop[i]),
            .load_val     (load_val[i*SEC_W +: SEC_W]),
            .remaining    (remaining[i*SEC_W +: SEC_W]),
            .running      (running[i]),
            .expired      (expired[i]),
            .expire_pulse (expire_pulse[i]),
            .warn         (warn[i])
        );
`else
        temporizador_canal #(
            .DIV   (DIV),
            .SEC_W (SEC_W)
        ) u_canal (
            .clk          (clk),
            .reset        (reset),
            .start        (start[i]),
            .pause        (pause[i]),
            .stop         (stop[i]),
            .load_val     (load_val[i*SEC_W +: SEC_W]),
            .remaining    (remaining[i*SEC_W +: SEC_W]),
            .running      (running[i]),
            .expired      (expired[i]),
            .expire_pulse (expire_pulse[i])
        );
`endif
    end

endmodule

// File: tb/tb_temporizador_multicanal.sv
// Bench for temporizador_multicanal: directed scenarios plus random traffic
// against an elapsed-active-cycles reference model.
module tb_temporizador_multicanal;

    localparam int CLK_HZ   = 10;
    localparam int TICK_HZ  = 1;
    localparam int DIV      = CLK_HZ / TICK_HZ;
    localparam int N_CH     = 2;
    localparam int SEC_W    = 7;
    localparam int WARN_SEC = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N_CH-1:0]       start, pause, stop;
    logic [N_CH*SEC_W-1:0] load_val;
    logic [N_CH*SEC_W-1:0] remaining;
    logic [N_CH-1:0]       running, expired, expire_pulse;
`ifdef TEMP_WARN_EN
    logic [N_CH-1:0]       warn;
`endif

    temporizador_multicanal #(
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .N_CH     (N_CH),
        .SEC_W    (SEC_W),
        .WARN_SEC (WARN_SEC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pause        (pause),
        .stop         (stop),
        .load_val     (load_val),
        .remaining    (remaining),
        .running      (running),
        .expired      (expired),
        .expire_pulse (expire_pulse)
`ifdef TEMP_WARN_EN
        , .warn       (warn)
`endif
    );

    always #5 clk = ~clk;

    int n_comp   = 0;
    int n_fallos = 0;

    // Model: 0 idle, 1 active (run/paused), 2 done; count = load - active_edges/DIV
    int m_st  [N_CH];
    int m_load[N_CH];
    int m_act [N_CH];
    int m_pul [N_CH];

    task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_comp++;
        if (obs !== esp) begin
            n_fallos++;
            $display("FAIL %s: obtenido=%0d esperado=%0d", tag, obs, esp);
        end
    endtask

    function automatic logic [N_CH*SEC_W-1:0] pk(input int a, input int b);
        logic [SEC_W-1:0] va, vb;
        va = SEC_W'(a);
        vb = SEC_W'(b);
        return {vb, va};
    endfunction

    task automatic modelo_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_st[c] = 0; m_load[c] = 0; m_act[c] = 0; m_pul[c] = 0;
        end
    endtask

    task automatic modelo_paso();
        int lv;
        for (int c = 0; c < N_CH; c++) begin
            lv = int'(load_val[c*SEC_W +: SEC_W]);
            m_pul[c] = 0;
            if (start[c]) begin
                m_load[c] = lv;
                m_act[c]  = 0;
                if (lv == 0) begin m_st[c] = 2; m_pul[c] = 1; end
                else m_st[c] = 1;
            end else if (stop[c]) begin
                m_st[c] = 0; m_load[c] = 0; m_act[c] = 0;
            end else if (m_st[c] == 1 && !pause[c]) begin
                m_act[c]++;
                if (m_act[c] / DIV >= m_load[c]) begin m_st[c] = 2; m_pul[c] = 1; end
            end
        end
    endtask

    function automatic int m_rem(input int c);
        return (m_st[c] == 1) ? m_load[c] - m_act[c] / DIV : 0;
    endfunction

    task automatic comprobar();
        for (int c = 0; c < N_CH; c++) begin
            verificar($sformatf("rem%0d", c), 32'(remaining[c*SEC_W +: SEC_W]), 32'(m_rem(c)));
            verificar($sformatf("run%0d", c), 32'(running[c]), 32'(m_st[c] == 1));
            verificar($sformatf("exp%0d", c), 32'(expired[c]), 32'(m_st[c] == 2));
            verificar($sformatf("pul%0d", c), 32'(expire_pulse[c]), 32'(m_pul[c]));
`ifdef TEMP_WARN_EN
            verificar($sformatf("warn%0d", c), 32'(warn[c]),
                      32'(m_st[c] == 1 && m_rem(c) > 0 && m_rem(c) <= WARN_SEC));
`endif
        end
    endtask

    task automatic paso(input logic [N_CH-1:0] st, input logic [N_CH-1:0] sp,
                        input logic [N_CH-1:0] pa, input logic [N_CH*SEC_W-1:0] lv);
        @(negedge clk);
        start = st; stop = sp; pause = pa; load_val = lv;
        @(posedge clk);
        modelo_paso();
        #1 comprobar();
    endtask

    task automatic reset_async();
        @(negedge clk);
        #2 reset = 1'b1;
        modelo_reset();
        #1 comprobar();
        @(negedge clk);
        reset = 1'b0;
    endtask

    int lat, p1;
    logic [N_CH-1:0] st_r, sp_r, pa_r;

    initial begin
        reset = 1'b1; start = '0; stop = '0; pause = '0; load_val = '0;
        modelo_reset();
        #12 comprobar();
        @(negedge clk) reset = 1'b0;

        // load 5: expiry 50 edges after start
        paso(2'b01, 2'b00, 2'b00, pk(5, 0));
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            paso(2'b00, 2'b00, 2'b00, pk(0, 0));
            if (expire_pulse[0]) begin lat = k; break; end
        end
        verificar("lat_carga5", 32'(lat), 32'd50);
        paso(2'b00, 2'b00, 2'b00, pk(0, 0));
        paso(2'b00, 2'b01, 2'b00, pk(0, 0));

        // 20-cycle pause straddling a prescaler wrap
        paso(2'b01, 2'b00, 2'b00, pk(5, 0));
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            paso(2'b00, 2'b00, {1'b0, (k >= 15 && k <= 34)}, pk(0, 0));
            if (expire_pulse[0]) begin lat = k; break; end
        end
        verificar("lat_pausa", 32'(lat), 32'd70);

        // load 0: immediate DONE
        paso(2'b01, 2'b00, 2'b00, pk(0, 0));
        verificar("cero_exp", 32'(expired[0]), 32'd1);
        verificar("cero_pul", 32'(expire_pulse[0]), 32'd1);
        verificar("cero_run", 32'(running[0]), 32'd0);
        paso(2'b00, 2'b00, 2'b00, pk(0, 0));
        verificar("cero_pul2", 32'(expire_pulse[0]), 32'd0);
        paso(2'b00, 2'b01, 2'b00, pk(0, 0));

        // two channels, stop ch1 mid-count
        paso(2'b11, 2'b00, 2'b00, pk(3, 6));
        lat = 0; p1 = 0;
        for (int k = 1; k <= 200; k++) begin
            paso(2'b00, (k == 25) ? 2'b10 : 2'b00, 2'b00, pk(0, 0));
            p1 += int'(expire_pulse[1]);
            if (expire_pulse[0]) begin lat = k; break; end
        end
        verificar("lat_ch0", 32'(lat), 32'd30);
        verificar("pul_ch1", 32'(p1), 32'd0);
        verificar("rem_ch1", 32'(remaining[SEC_W +: SEC_W]), 32'd0);
        paso(2'b00, 2'b11, 2'b00, pk(0, 0));

        // reset at count 4, then restart
        paso(2'b01, 2'b00, 2'b00, pk(5, 0));
        for (int k = 1; k <= 15; k++) paso(2'b00, 2'b00, 2'b00, pk(0, 0));
        verificar("rem_antes_rst", 32'(remaining[0 +: SEC_W]), 32'd4);
        reset_async();
        paso(2'b01, 2'b00, 2'b00, pk(5, 0));
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            paso(2'b00, 2'b00, 2'b00, pk(0, 0));
            if (expire_pulse[0]) begin lat = k; break; end
        end
        verificar("lat_tras_rst", 32'(lat), 32'd50);

        // random traffic
        pa_r = '0;
        for (int it = 0; it < 3000; it++) begin
            for (int c = 0; c < N_CH; c++) begin
                st_r[c] = ($urandom_range(0, 39) == 0);
                sp_r[c] = ($urandom_range(0, 79) == 0);
                if ($urandom_range(0, 9) == 0) pa_r[c] = ~pa_r[c];
            end
            if (it == 1500) reset_async();
            paso(st_r, sp_r, pa_r, pk($urandom_range(0, 4), $urandom_range(0, 4)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_fallos);
        $finish;
    end

endmodule
